// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
//   Shared helpers for the branch target predictor:
//     - clog2()          : index width derived from table depth
//     - ctr_reset_val()  : PHT counter reset value (weakly not-taken, 2^(w-1)-1)
//     - ctr_max_val()    : PHT counter saturation ceiling (2^w-1)
//   The BTB entry struct is declared inside the top module because its tag and
//   target widths follow the top-level parameters.
// ----------------------------------------------------------------------------
package bp_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ctr_reset_val(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int ctr_max_val(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_target_predictor_if
//   Bundles the fetch lookup, decode training and debug counter signals.
//   slave  : the predictor (consumes fetch/update, produces predictions)
//   master : the fetch/decode side
//   Lookup : fetch_pc -> pred_taken, pred_hit, pred_target, pred_hist
//   Update : upd_valid, upd_pc, upd_taken, upd_target, upd_pred, upd_hist
//   Debug  : mispred_cnt
// ----------------------------------------------------------------------------
interface branch_target_predictor_if #(
  parameter int PC_W   = 8,
  parameter int HIST_W = 4,
  parameter int CNT_W  = 16
);
  logic [PC_W-1:0]   fetch_pc;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              pred_hit;
  logic [HIST_W-1:0] pred_hist;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [PC_W-1:0]   upd_target;
  logic              upd_pred;
  logic [HIST_W-1:0] upd_hist;
  logic [CNT_W-1:0]  mispred_cnt;

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred, upd_hist,
    output pred_taken, pred_target, pred_hit, pred_hist, mispred_cnt
  );

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred, upd_hist,
    input  pred_taken, pred_target, pred_hit, pred_hist, mispred_cnt
  );
endinterface

// File: rtl/bp_sat_counter.sv
// ----------------------------------------------------------------------------
// bp_sat_counter
//   Up/down counter that saturates at 0 and at all-ones (never wraps).
//   Used for each PHT entry and for the mispredict counter.
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active-low, loads RST_VAL
//   inc_i   : count up this edge
//   dec_i   : count down this edge (inc_i and dec_i together hold)
//   cnt_o   : current count
// ----------------------------------------------------------------------------
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int W       = 2,
  parameter int RST_VAL = ctr_reset_val(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= W'(RST_VAL);
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_target_predictor.sv
// ----------------------------------------------------------------------------
// branch_target_predictor
//   Fetch-stage predictor: PHT of saturating counters for direction plus a
//   tagged BTB for the target. Lookup is combinational on fetch_pc; training
//   from decode is applied on the rising edge when upd_valid && en.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low (clears BTB, PHT to weakly
//          not-taken, GHR, mispredict count)
//   en   : pipeline enable; 0 freezes all state, lookup stays valid
//   bus  : branch_target_predictor_if.slave (lookup, update, mispred_cnt)
//   Optional: define BTP_GSHARE_EN to index the PHT with pc XOR global
//   history; otherwise the PHT is indexed by pc alone and pred_hist is 0.
// ----------------------------------------------------------------------------
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int HIST_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  branch_target_predictor_if.slave bus
);

  localparam int IDX_W = clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  btb_entry_t       btb_q [ENTRIES];
  logic [CTR_W-1:0] pht_cnt [ENTRIES];

  logic             upd_fire;
  logic [IDX_W-1:0] fetch_bidx, upd_bidx;
  logic [IDX_W-1:0] fetch_pidx, upd_pidx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  btb_entry_t       lk_entry;

  assign upd_fire   = en && bus.upd_valid;
  assign fetch_bidx = bus.fetch_pc[IDX_W-1:0];
  assign fetch_tag  = bus.fetch_pc[PC_W-1:IDX_W];
  assign upd_bidx   = bus.upd_pc[IDX_W-1:0];
  assign upd_tag    = bus.upd_pc[PC_W-1:IDX_W];

`ifdef BTP_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;

  // History is trained from resolved outcomes only (non-speculative); the
  // truncating cast drops the oldest bit and works for HIST_W == 1 too.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_fire) ghr_d = HIST_W'({ghr_q, bus.upd_taken});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  // Update uses the history that was live at lookup time, carried back by decode.
  assign fetch_pidx    = fetch_bidx ^ IDX_W'(ghr_q);
  assign upd_pidx      = upd_bidx ^ IDX_W'(bus.upd_hist);
  assign bus.pred_hist = ghr_q;
`else
  logic unused_upd_hist;
  assign unused_upd_hist = ^bus.upd_hist;
  assign fetch_pidx      = fetch_bidx;
  assign upd_pidx        = upd_bidx;
  assign bus.pred_hist   = '0;
`endif

  // BTB: only taken branches allocate; a taken update replaces any alias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else if (upd_fire && bus.upd_taken) begin
      btb_q[upd_bidx] <= '{valid: 1'b1, tag: upd_tag, target: bus.upd_target};
    end
  end

  // PHT: one saturating counter per entry, selected by the update index.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_pht
    logic sel;
    assign sel = upd_fire && (upd_pidx == IDX_W'(gi));

    bp_sat_counter #(
      .W       (CTR_W),
      .RST_VAL (ctr_reset_val(CTR_W))
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc_i (sel && bus.upd_taken),
      .dec_i (sel && !bus.upd_taken),
      .cnt_o (pht_cnt[gi])
    );
  end

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign lk_entry        = btb_q[fetch_bidx];
  assign bus.pred_hit    = lk_entry.valid && (lk_entry.tag == fetch_tag);
  assign bus.pred_target = bus.pred_hit ? lk_entry.target : '0;
  assign bus.pred_taken  = bus.pred_hit && pht_cnt[fetch_pidx][CTR_W-1];

  bp_sat_counter #(
    .W       (CNT_W),
    .RST_VAL (0)
  ) u_mispred (
    .clk   (clk),
    .rst   (rst),
    .inc_i (upd_fire && (bus.upd_pred != bus.upd_taken)),
    .dec_i (1'b0),
    .cnt_o (bus.mispred_cnt)
  );

endmodule
